// File: rtl/mmul_pkg.sv
// Shared definitions for the mmul operand loader and its neighbours.
// Holds the loader state encoding, default matrix geometry and the
// element-counter width helper.
package mmul_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  localparam int DEF_M     = 3;
  localparam int DEF_N     = 3;
  localparam int DEF_K     = 3;
  localparam int DEF_L     = 3;
  localparam int DEF_WIDTH = 8;

  localparam int A_ELEMS = DEF_M * DEF_N;
  localparam int B_ELEMS = DEF_K * DEF_L;

  // Counter must index the larger operand; never narrower than one bit.
  function automatic int cnt_width(input int a_elems, input int b_elems);
    int m;
    m = (a_elems > b_elems) ? a_elems : b_elems;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int CNT_W = cnt_width(A_ELEMS, B_ELEMS);

endpackage

// File: rtl/elem_packer.sv
// Flat operand register: writes one WIDTH-bit element per cycle at wr_idx.
// Ports: clk/reset (sync, active-low), wr_en/wr_idx/wr_dat write port,
//        vec = packed register contents, element e at [e*WIDTH +: WIDTH].
module elem_packer #(
  parameter int ELEMS = 9,
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic [ELEMS*WIDTH-1:0] vec
);

  logic [ELEMS*WIDTH-1:0] vec_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vec_q <= '0;
    end else if (wr_en) begin
      for (int e = 0; e < ELEMS; e++) begin
        if (wr_idx == IDX_W'(e)) begin
          vec_q[e*WIDTH +: WIDTH] <= wr_dat;
        end
      end
    end
  end

  assign vec = vec_q;

endmodule

// File: rtl/matrix_loader.sv
// Streams A then B elements into packed operands and holds mmul enabled
// until it reports done/invalid. Ports: valid/ready element stream with
// in_last framing, mat_a/mat_b/enable to mmul, op_done/err status pulses.
module matrix_loader
  import mmul_pkg::*;
#(
  parameter int M     = DEF_M,
  parameter int N     = DEF_N,
  parameter int K     = DEF_K,
  parameter int L     = DEF_L,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic [M*N*WIDTH-1:0]   mat_a,
  output logic [K*L*WIDTH-1:0]   mat_b,
  output logic                   enable,
  input  logic                   mmul_done,
  input  logic                   mmul_invalid,
  output logic                   op_done,
  output logic                   err
);

  localparam int A_N = M * N;
  localparam int B_N = K * L;
  localparam int CW  = cnt_width(A_N, B_N);
  localparam logic [CW-1:0] A_LAST = CW'(A_N - 1);
  localparam logic [CW-1:0] B_LAST = CW'(B_N - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          enable_q;
  logic          op_done_q;
  logic          err_q;

  logic fire;
  logic b_final;
  logic wr_a;
  logic wr_b;

  assign fire    = in_valid & in_ready_q;
  assign b_final = (cnt_q == B_LAST);
  // An in_last beat is only meaningful on the final B slot; anywhere else it
  // is a framing error and must not touch the operands.
  assign wr_a = fire && (state_q == LOAD_A) && !in_last;
  // The final B beat is written even without in_last (the frame is still
  // flagged and flushed afterwards).
  assign wr_b = fire && (state_q == LOAD_B) && (b_final || !in_last);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      enable_q   <= 1'b0;
      op_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      op_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        LOAD_A: begin
          if (fire) begin
            if (in_last) begin
              err_q <= 1'b1;
              cnt_q <= '0;
            end else if (cnt_q == A_LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (fire) begin
            if (b_final) begin
              cnt_q <= '0;
              if (in_last) begin
                state_q    <= RUN;
                in_ready_q <= 1'b0;
                enable_q   <= 1'b1;
              end else begin
                err_q   <= 1'b1;
                state_q <= FLUSH;
              end
            end else if (in_last) begin
              err_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= LOAD_A;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        RUN: begin
          // invalid wins over done when both arrive together
          if (mmul_invalid) begin
            err_q      <= 1'b1;
            state_q    <= LOAD_A;
            in_ready_q <= 1'b1;
            enable_q   <= 1'b0;
          end else if (mmul_done) begin
            op_done_q  <= 1'b1;
            state_q    <= LOAD_A;
            in_ready_q <= 1'b1;
            enable_q   <= 1'b0;
          end
        end
        FLUSH: begin
          if (fire && in_last) begin
            state_q <= LOAD_A;
          end
        end
        default: begin
          state_q    <= LOAD_A;
          cnt_q      <= '0;
          in_ready_q <= 1'b1;
          enable_q   <= 1'b0;
        end
      endcase
    end
  end

  elem_packer #(.ELEMS(A_N), .WIDTH(WIDTH), .IDX_W(CW)) u_pack_a (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_a),
    .wr_idx (cnt_q),
    .wr_dat (in_data),
    .vec    (mat_a)
  );

  elem_packer #(.ELEMS(B_N), .WIDTH(WIDTH), .IDX_W(CW)) u_pack_b (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_b),
    .wr_idx (cnt_q),
    .wr_dat (in_data),
    .vec    (mat_b)
  );

  assign in_ready = in_ready_q;
  assign enable   = enable_q;
  assign op_done  = op_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: table of frames with expected packed operands,
// pushed to a scoreboard queue on send and popped when enable rises, plus
// hand-written sequences for framing errors, aborts and mid-operation reset.
module tb_matrix_loader;
  import mmul_pkg::*;

  localparam int BEATS = A_ELEMS + B_ELEMS;

  typedef logic [7:0] beats_t [BEATS];
  typedef struct {
    beats_t      bt;
    logic [71:0] a;
    logic [71:0] b;
    bit          thr;
    bit          inv;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic [71:0] mat_a;
  logic [71:0] mat_b;
  logic        enable;
  logic        mmul_done = 1'b0;
  logic        mmul_invalid = 1'b0;
  logic        op_done;
  logic        err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [143:0] sb_q [$];
  vec_t tbl [4];

  matrix_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .mat_a        (mat_a),
    .mat_b        (mat_b),
    .enable       (enable),
    .mmul_done    (mmul_done),
    .mmul_invalid (mmul_invalid),
    .op_done      (op_done),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one beat; returns #1 after the edge that accepted it.
  task automatic beat(input logic [7:0] d, input logic last);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk("beat_ready_timeout", 72'(in_ready), 72'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_range(input beats_t bt, input int lo, input int hi,
                            input bit thr, input bit last_on_final);
    for (int i = lo; i <= hi; i++) begin
      if (thr) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      beat(bt[i], last_on_final && (i == BEATS - 1));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 72'(in_ready), 72'd1);
    chk({tag, "_enable"},   72'(enable),   72'd0);
    chk({tag, "_mat_a"},    mat_a,         72'd0);
    chk({tag, "_mat_b"},    mat_b,         72'd0);
    chk({tag, "_op_done"},  72'(op_done),  72'd0);
    chk({tag, "_err"},      72'(err),      72'd0);
  endtask

  task automatic end_run(input bit inv);
    mmul_done    = 1'b1;
    mmul_invalid = inv;
    @(posedge clk); #1;
    mmul_done    = 1'b0;
    mmul_invalid = 1'b0;
    chk("end_op_done", 72'(op_done), 72'(!inv));
    chk("end_err",     72'(err),     72'(inv));
    chk("end_enable",  72'(enable),  72'd0);
    chk("end_ready",   72'(in_ready), 72'd1);
    @(posedge clk); #1;
    chk("end_op_done_pulse", 72'(op_done), 72'd0);
    chk("end_err_pulse",     72'(err),     72'd0);
  endtask

  task automatic run_vec(input vec_t v, input bit hold);
    int start;
    logic [143:0] e;
    sb_q.push_back({v.a, v.b});
    start = cyc;
    send_range(v.bt, 0, BEATS - 2, v.thr, 1'b1);
    chk("enable_before_last", 72'(enable), 72'd0);
    send_range(v.bt, BEATS - 1, BEATS - 1, v.thr, 1'b1);
    chk("enable_after_last", 72'(enable), 72'd1);
    chk("ready_in_run", 72'(in_ready), 72'd0);
    if (!v.thr) chk("frame_cycles", 72'(cyc - start), 72'd18);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 72'd0, 72'd1);
    end else begin
      e = sb_q.pop_front();
      chk("mat_a", mat_a, e[143:72]);
      chk("mat_b", mat_b, e[71:0]);
      if (hold) begin
        for (int c = 0; c < 10; c++) begin
          @(posedge clk); #1;
          chk("hold_enable", 72'(enable), 72'd1);
          chk("hold_ready",  72'(in_ready), 72'd0);
          chk("hold_mat_a",  mat_a, e[143:72]);
          chk("hold_mat_b",  mat_b, e[71:0]);
        end
      end
    end
    end_run(v.inv);
  endtask

  initial begin
    beats_t t1;
    t1 = '{8'd2, 8'd8, 8'd3, 8'd5, 8'd0, 8'd1, 8'd3, 8'd2, 8'd1,
           8'd8, 8'd0, 8'd2, 8'd1, 8'd6, 8'd5, 8'd3, 8'd0, 8'd0};

    tbl[0].bt = t1; tbl[0].a = 72'h010203010005030802; tbl[0].b = 72'h000003050601020008;
    tbl[0].thr = 1'b0; tbl[0].inv = 1'b0;
    tbl[1].a = 72'h112233445566778899; tbl[1].b = 72'hA1B2C3D4E5F6071829;
    tbl[1].thr = 1'b0; tbl[1].inv = 1'b1;
    tbl[2].bt = t1; tbl[2].a = 72'h010203010005030802; tbl[2].b = 72'h000003050601020008;
    tbl[2].thr = 1'b1; tbl[2].inv = 1'b0;
    tbl[3].a = 72'hFFEEDDCCBBAA998877; tbl[3].b = 72'h0F1E2D3C4B5A697887;
    tbl[3].thr = 1'b1; tbl[3].inv = 1'b0;
    // Frames without a literal beat list are sent in packing order.
    for (int k = 1; k < 4; k += 2) begin
      for (int i = 0; i < BEATS; i++) begin
        tbl[k].bt[i] = (i < A_ELEMS) ? tbl[k].a[i*8 +: 8] : tbl[k].b[(i-A_ELEMS)*8 +: 8];
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b1;

    // done outside RUN is ignored
    mmul_done = 1'b1;
    @(posedge clk); #1;
    mmul_done = 1'b0;
    chk("idle_done_op_done", 72'(op_done), 72'd0);
    chk("idle_done_ready",   72'(in_ready), 72'd1);

    // Table-driven frames (first one holds RUN for 10 cycles)
    for (int k = 0; k < 4; k++) begin
      run_vec(tbl[k], k == 0);
    end

    // Early in_last on beat 5
    send_range(tbl[1].bt, 0, 3, 1'b0, 1'b0);
    beat(tbl[1].bt[4], 1'b1);
    chk("early_err", 72'(err), 72'd1);
    chk("early_enable", 72'(enable), 72'd0);
    @(posedge clk); #1;
    chk("early_err_pulse", 72'(err), 72'd0);
    run_vec(tbl[3], 1'b0);

    // Missing in_last, then junk flushed
    send_range(tbl[1].bt, 0, BEATS - 1, 1'b0, 1'b0);
    chk("nolast_err", 72'(err), 72'd1);
    chk("nolast_enable", 72'(enable), 72'd0);
    beat(8'hAA, 1'b0);
    chk("flush_err_pulse", 72'(err), 72'd0);
    beat(8'hBB, 1'b0);
    beat(8'hCC, 1'b1);
    chk("flush_mat_a", mat_a, tbl[1].a);
    chk("flush_mat_b", mat_b, tbl[1].b);
    chk("flush_enable", 72'(enable), 72'd0);
    run_vec(tbl[0], 1'b0);

    // Reset mid-frame
    send_range(tbl[3].bt, 0, 6, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("rst_frame");
    reset = 1'b1;

    // Reset mid-RUN
    send_range(tbl[1].bt, 0, BEATS - 1, 1'b0, 1'b1);
    chk("pre_rst_enable", 72'(enable), 72'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("rst_run");
    reset = 1'b1;
    run_vec(tbl[2], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for `mmul`. Accepts a stream of matrix elements, one per cycle, over a valid/ready handshake, and packs them into the flat `mat_a`/`mat_b` operand vectors. It holds `enable` high with stable operands until `mmul` reports `done` or `invalid`, then returns to loading the next pair. Streams with a bad `in_last` marker are dropped and flagged without starting `mmul`.

## Interface

**Parameters**
- `M`, default 3: rows of A.
- `N`, default 3: columns of A.
- `K`, default 3: rows of B.
- `L`, default 3: columns of B.
- `WIDTH`, default 8: element width in bits.

**Ports**
- `clk`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `in_valid`, in, 1: element beat present.
- `in_ready`, out, 1: loader accepts a beat this cycle.
- `in_data`, in, WIDTH: element value.
- `in_last`, in, 1: marks the final beat of a frame (last element of B).
- `mat_a`, out, M*N*WIDTH: packed A operand, to `mmul.mat_a`.
- `mat_b`, out, K*L*WIDTH: packed B operand, to `mmul.mat_b`.
- `enable`, out, 1: to `mmul.enable`.
- `mmul_done`, in, 1: from `mmul.done`.
- `mmul_invalid`, in, 1: from `mmul.invalid`.
- `op_done`, out, 1: one-cycle pulse when a multiply completes.
- `err`, out, 1: one-cycle pulse on a framing error or an `mmul_invalid` abort.

## Operation

**Packing.** Element (i,j) of A sits at `mat_a[(i*N+j)*WIDTH +: WIDTH]`. B uses the same rule with row length L.

**Stream order.** A frame is M*N beats of A in row-major order, then K*L beats of B in row-major order. `in_last` is high only on the final B beat.

**States.** Reset state is LOAD_A. The element counter is sized by `$clog2` of max(M*N, K*L).

- **LOAD_A**
  - `in_ready` = 1. Each accepted beat writes its A slot and increments the counter.
  - After beat M*N−1, clear the counter and go to LOAD_B.
- **LOAD_B**
  - `in_ready` = 1. Each accepted beat writes its B slot.
  - Final beat (index K*L−1) with `in_last` = 1: go to RUN.
  - Final beat with `in_last` = 0: pulse `err`, go to FLUSH.
- **RUN**
  - `in_ready` = 0, `enable` = 1. Operand registers are frozen.
  - `mmul_done` = 1: go to LOAD_A and pulse `op_done`.
  - `mmul_invalid` = 1: go to LOAD_A and pulse `err`. `invalid` has priority if both are high.
- **FLUSH**
  - `in_ready` = 1. Accepted beats are discarded.
  - Beat with `in_last` = 1 is accepted and discarded; then go to LOAD_A.

**Early `in_last`.** An accepted beat with `in_last` = 1 before the final B beat, in LOAD_A or LOAD_B:
- beat is discarded;
- `err` pulses;
- counter clears;
- next state is LOAD_A.

**Operand registers.** They are not cleared between frames. Every slot is rewritten before RUN is entered.

## Timing

**Reset values:**
- `in_ready` = 1 (LOAD_A).
- `enable` = 0.
- `mat_a` = 0, `mat_b` = 0.
- `op_done` = 0, `err` = 0.

**Handshake.** A beat transfers in a cycle where `in_valid` and `in_ready` are both high. `in_ready` is a registered function of state only, with no combinational path from `in_valid`.

**Frame to `enable`.** If the final B beat is accepted at edge t, `enable` is 1 from t+1. This happens only if the write completed, so `mat_b` is final in the same cycle.

**Back-to-back.** Full throughput is one beat per cycle. A 9+9 frame takes 18 cycles from the first accepted beat to `enable`.

**Completion.**
- `mmul_done` or `mmul_invalid` sampled high at edge d.
- `enable` = 0 from d+1.
- `op_done` or `err` is high for the cycle d..d+1 only.
- `in_ready` = 1 from d+1.

**Reset mid-operation.** Reset in any state returns to LOAD_A with all outputs at reset values on the next edge. `enable` drops at that edge.

**`mmul_done` / `mmul_invalid` outside RUN.** Ignored.

## Structure

- **Shared package `mmul_pkg`:** state encoding for LOAD_A, LOAD_B, RUN, FLUSH, plus localparams `A_ELEMS` = M*N, `B_ELEMS` = K*L, `CNT_W`. The same localparams are reused by the `mmul` bench.
- **Single sub-module `elem_packer`:** parameterised by element count and WIDTH. Handles write-enable plus index into a flat register vector. It is instantiated twice, once for A and once for B.
- The FSM and counter stay in `matrix_loader`.

## Test plan

1. **Nominal frame.**
   - Stimulus: beats 2,8,3,5,0,1,3,2,1 then 8,0,2,1,6,5,3,0,0 with `in_last` on the 18th beat.
   - Required: `mat_a` = 72'h010203010005030802, `mat_b` = 72'h000003050601020008, and `enable` rises the cycle after beat 18.
2. **Completion handshake.** Hold `mmul_done` low for 10 cycles in RUN, then high for 1 cycle. Required: `enable` stays 1 with operands frozen and `in_ready` = 0; then `op_done` pulses once, `enable` = 0, and `in_ready` = 1.
3. **Early `in_last`.** Assert `in_last` on beat 5. Required: `err` pulses once, no `enable`, and a following clean frame loads correctly.
4. **Missing `in_last`.** Send 18 beats with no `in_last`, then 3 junk beats, the last with `in_last`. Required: `err` on beat 18, junk discarded, `mat_a` unchanged by the junk, and the next frame is good.
5. **Invalid abort and throttling.** With `mmul_invalid` = 1 in RUN, `err` pulses and `op_done` stays 0. Toggle `in_valid` randomly during a frame: the same packed result as test 1.
6. **Reset mid-frame and mid-RUN.** Pull `reset` low after 7 beats, and separately during RUN. Required: outputs return to reset values at the next edge and `enable` = 0.
